// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM access sequencer.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        WR_DONE
    } state_t;

    localparam int         CNT_W    = 4;
    localparam logic [3:0] ADDR_PAD = 4'b0000;

endpackage

// File: rtl/sram_bus_ctrl_strobe_timer.sv
// Loadable down-counter timing the OE/WE strobe width; shared by read and write paths.
module strobe_timer
    import slc3_mem_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Saturates at zero so a stray enable can never wrap the count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Request/ready SRAM access sequencer: drives CE/OE/WE/UB/LB timing and captures read data.
module sram_bus_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 16
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [15:0]       addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic [19:0]       ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              data_oe
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_load;
    logic              w_en;
    logic              w_zero;
    logic              w_latch_addr;
    logic              w_latch_wdata;
    logic              w_capture;
    logic              w_ce_n, w_oe_n, w_we_n, w_bytes_n, w_data_oe, w_ready, w_busy;

    logic [15:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ce_n, r_oe_n, r_we_n, r_bytes_n, r_data_oe, r_ready, r_busy;

    strobe_timer u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_en          = 1'b0;
        w_latch_addr  = 1'b0;
        w_latch_wdata = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                // Write has priority; a simultaneous read request is dropped.
                if (req_wr) begin
                    w_state_next  = WR_SETUP;
                    w_latch_addr  = 1'b1;
                    w_latch_wdata = 1'b1;
                end else if (req_rd) begin
                    w_state_next = RD_STROBE;
                    w_latch_addr = 1'b1;
                    w_load       = 1'b1;
                end
            end
            RD_STROBE: begin
                if (w_zero) begin
                    w_state_next = RD_DONE;
                    w_capture    = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            RD_DONE:  w_state_next = IDLE;
            WR_SETUP: begin
                w_state_next = WR_PULSE;
                w_load       = 1'b1;
            end
            WR_PULSE: begin
                if (w_zero) begin
                    w_state_next = WR_HOLD;
                end else begin
                    w_en = 1'b1;
                end
            end
            WR_HOLD:  w_state_next = WR_DONE;
            WR_DONE:  w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Output values are decoded from the next state and registered alongside it.
    always_comb begin
        w_ce_n    = 1'b1;
        w_oe_n    = 1'b1;
        w_we_n    = 1'b1;
        w_bytes_n = 1'b1;
        w_data_oe = 1'b0;
        w_ready   = 1'b0;
        w_busy    = (w_state_next != IDLE);
        case (w_state_next)
            RD_STROBE: begin
                w_ce_n    = 1'b0;
                w_oe_n    = 1'b0;
                w_bytes_n = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                w_ce_n    = 1'b0;
                w_bytes_n = 1'b0;
                w_data_oe = 1'b1;
            end
            WR_PULSE: begin
                w_ce_n    = 1'b0;
                w_we_n    = 1'b0;
                w_bytes_n = 1'b0;
                w_data_oe = 1'b1;
            end
            RD_DONE, WR_DONE: w_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_bytes_n <= 1'b1;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ce_n    <= w_ce_n;
            r_oe_n    <= w_oe_n;
            r_we_n    <= w_we_n;
            r_bytes_n <= w_bytes_n;
            r_data_oe <= w_data_oe;
            r_ready   <= w_ready;
            r_busy    <= w_busy;
            if (w_latch_addr) begin
                r_addr <= addr_in;
            end
            if (w_latch_wdata) begin
                r_wdata <= wdata;
            end
            if (w_capture) begin
                r_rdata <= Data_from_SRAM;
            end
        end
    end

    assign ADDR         = {ADDR_PAD, r_addr};
    assign Data_to_SRAM = r_wdata;
    assign rdata        = r_rdata;
    assign CE           = r_ce_n;
    assign OE           = r_oe_n;
    assign WE           = r_we_n;
    assign UB           = r_bytes_n;
    assign LB           = r_bytes_n;
    assign data_oe      = r_data_oe;
    assign ready        = r_ready;
    assign busy         = r_busy;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: table of accesses plus reset corner cases.
module tb_sram_bus_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_rd, req_wr;
    logic [15:0] addr_in, wdata, Data_from_SRAM;
    logic [15:0] rdata, Data_to_SRAM;
    logic        ready, busy, CE, UB, LB, OE, WE, data_oe;
    logic [19:0] ADDR;

    int n_checks = 0;
    int n_fail   = 0;

    sram_bus_ctrl #(.WAIT_CYCLES(2), .DATA_W(16)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .req_rd         (req_rd),
        .req_wr         (req_wr),
        .addr_in        (addr_in),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready),
        .busy           (busy),
        .ADDR           (ADDR),
        .CE             (CE),
        .UB             (UB),
        .LB             (LB),
        .OE             (OE),
        .WE             (WE),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .data_oe        (data_oe)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        do_rd;
        logic        do_wr;
        logic        disturb;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] sram;
        int          exp_ready;
        int          exp_oe;
        int          exp_we;
        int          exp_doe;
        int          exp_ce;
        logic [15:0] exp_rdata;
        logic [19:0] exp_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int oe_n, we_n, doe_n, ce_n, viol, addr_bad, dts_bad, rdy_cyc, rdy_cnt;
        oe_n = 0; we_n = 0; doe_n = 0; ce_n = 0; viol = 0;
        addr_bad = 0; dts_bad = 0; rdy_cyc = -1; rdy_cnt = 0;
        @(negedge Clk);
        addr_in        = v.addr;
        wdata          = v.wd;
        Data_from_SRAM = v.sram;
        req_rd         = v.do_rd;
        req_wr         = v.do_wr;
        @(posedge Clk);
        for (int c = 1; c <= v.exp_ready + 2; c++) begin
            @(negedge Clk);
            if (!OE) oe_n++;
            if (!WE) we_n++;
            if (!CE) ce_n++;
            if (data_oe) doe_n++;
            if (busy && ADDR !== v.exp_addr) addr_bad++;
            if (data_oe && Data_to_SRAM !== v.wd) dts_bad++;
            if (!OE && !WE) viol++;
            if (data_oe && !OE) viol++;
            if ((!OE || !WE) && (CE || UB || LB)) viol++;
            if (ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) rdy_cyc = c;
                req_rd = 1'b0;
                req_wr = 1'b0;
            end
            if (v.disturb && c == 1) begin
                addr_in = 16'hFFFF;
                req_wr  = 1'b1;
            end
            if (v.disturb && c == 2) req_wr = 1'b0;
        end
        check($sformatf("v%0d ready_cycle", idx), 32'(rdy_cyc), 32'(v.exp_ready));
        check($sformatf("v%0d ready_count", idx), 32'(rdy_cnt), 32'd1);
        check($sformatf("v%0d oe_low_cycles", idx), 32'(oe_n), 32'(v.exp_oe));
        check($sformatf("v%0d we_low_cycles", idx), 32'(we_n), 32'(v.exp_we));
        check($sformatf("v%0d data_oe_cycles", idx), 32'(doe_n), 32'(v.exp_doe));
        check($sformatf("v%0d ce_low_cycles", idx), 32'(ce_n), 32'(v.exp_ce));
        check($sformatf("v%0d strobe_rules", idx), 32'(viol), 32'd0);
        check($sformatf("v%0d addr_stable", idx), 32'(addr_bad), 32'd0);
        check($sformatf("v%0d wdata_driven", idx), 32'(dts_bad), 32'd0);
        check($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d idle_after", idx), 32'(busy), 32'd0);
        $display("vec %0d rd=%0b wr=%0b addr=%h ready@%0d rdata=%h", idx, v.do_rd, v.do_wr, v.addr, rdy_cyc, rdata);
    endtask

    initial begin
        int rdy_seen;
        int we_low_found;
        //                  rd    wr    dist  addr      wd        sram      rdy oe we doe ce rdata     addr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'hBEEF, 3, 2, 0, 0, 2, 16'hBEEF, 20'h00042};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'hA5A5, 16'h0000, 5, 0, 2, 4, 4, 16'hBEEF, 20'h01234};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0777, 16'h1357, 16'h9999, 5, 0, 2, 4, 4, 16'hBEEF, 20'h00777};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0042, 16'h2222, 16'h0F0F, 3, 2, 0, 0, 2, 16'h0F0F, 20'h00042};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h3333, 16'h1234, 3, 2, 0, 0, 2, 16'h1234, 20'h0FFFF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h4444, 16'hCAFE, 3, 2, 0, 0, 2, 16'hCAFE, 20'h00ABC};

        Reset = 1'b0; req_rd = 1'b1; req_wr = 1'b0;
        addr_in = 16'h0042; wdata = 16'h0000; Data_from_SRAM = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            check($sformatf("reset c%0d strobes_busy_ready", c),
                  {27'd0, CE, OE, WE, busy, ready}, 32'b11100);
            check($sformatf("reset c%0d rdata_oe_addr", c),
                  {data_oe, rdata, ADDR[14:0]}, 32'd0);
        end
        $display("reset hold: CE=%b OE=%b WE=%b busy=%b ready=%b rdata=%h", CE, OE, WE, busy, ready, rdata);
        req_rd = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset asserted during the WE pulse must abort without a clock edge.
        @(negedge Clk);
        addr_in = 16'h0ABC; wdata = 16'h5A5A; req_wr = 1'b1;
        @(posedge Clk);
        we_low_found = 0;
        for (int c = 0; c < 10 && we_low_found == 0; c++) begin
            @(negedge Clk);
            if (!WE) we_low_found = 1;
        end
        check("midrst we_pulse_reached", 32'(we_low_found), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("midrst we_high", 32'(WE), 32'd1);
        check("midrst data_oe_low", 32'(data_oe), 32'd0);
        check("midrst ce_high", 32'(CE), 32'd1);
        check("midrst busy_low", 32'(busy), 32'd0);
        check("midrst rdata_cleared", 32'(rdata), 32'd0);
        $display("reset mid-write: WE=%b data_oe=%b CE=%b busy=%b", WE, data_oe, CE, busy);
        req_wr = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (ready) rdy_seen++;
        end
        check("midrst no_ready", 32'(rdy_seen), 32'd0);
        Reset = 1'b1;

        run_vec(vecs[5], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
